// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and select-encoding helper for the
// round-robin demux dispatcher.
package demux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        DRIVE
    } state_e;

    // Channel index to the demux select lines, returned as {s2,s1,s0}.
    function automatic logic [2:0] sel_to_bits(input logic [SEL_W-1:0] sel);
        return {sel[2], sel[1], sel[0]};
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority finder: returns the first set bit of elig_i searching
// from ptr_i+1 upward (mod 8), so channel ptr_i has the lowest priority.
module rr_pick8
    import demux_pkg::*;
(
    input  logic [NCH-1:0]   elig_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = ptr_i + SEL_W'(i);
            if (!found_o && elig_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Accepts words over valid/ready, picks an enabled and ready channel by
// round-robin, and drives the 1-to-8 demux inputs for HOLD cycles.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DW      = 1,
    parameter int HOLD    = 1,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic [NCH-1:0] ch_ready,
    input  logic [NCH-1:0] ch_mask,
    output logic [DW-1:0]  d,
    output logic           s2,
    output logic           s1,
    output logic           s0,
    output logic           out_valid,
    output logic           drop,
    output logic [7:0]     stall_cnt
);

    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e           state_q, state_d;
    logic [DW-1:0]    word_q, word_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             drop_q, drop_d;
    logic [7:0]       stall_q, stall_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [WCW-1:0]   wait_q, wait_d;

    logic             found;
    logic [SEL_W-1:0] idx;

    rr_pick8 u_pick (
        .elig_i  (ch_ready & ch_mask),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (idx)
    );

    assign in_ready     = (state_q == IDLE) && !rst;
    assign d            = dout_q;
    assign {s2, s1, s0} = sel_to_bits(sel_q);
    assign out_valid    = valid_q;
    assign drop         = drop_q;
    assign stall_cnt    = stall_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        stall_d = stall_q;
        hold_d  = hold_q;
        wait_d  = wait_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    word_d  = in_data;
                    wait_d  = '0;
                    state_d = ARB;
                end
            end

            // A grant in the same cycle as the timeout takes precedence.
            ARB: begin
                if (found) begin
                    sel_d   = idx;
                    dout_d  = word_q;
                    valid_d = 1'b1;
                    hold_d  = HCW'(HOLD - 1);
                    state_d = DRIVE;
                end else begin
                    if (stall_q != 8'hFF) begin
                        stall_d = stall_q + 8'd1;
                    end
                    if (TIMEOUT != 0) begin
                        wait_d = wait_q + 1'b1;
                        if (wait_q == WCW'(TIMEOUT - 1)) begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end

            // Select keeps its last value after release; only d and valid clear.
            DRIVE: begin
                if (hold_q == '0) begin
                    dout_d  = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            dout_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NCH - 1);
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            stall_q <= '0;
            hold_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            stall_q <= stall_d;
            hold_q  <= hold_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher: one instance with HOLD=1 and one
// with HOLD=3, both TIMEOUT=16.
module tb_demux_rr_dispatcher;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, s2, s1, s0, out_valid, drop;
    logic [0:0] in_data, d;
    logic [7:0] ch_ready, ch_mask, stall_cnt;
    logic [2:0] sel;
    assign sel = {s2, s1, s0};

    logic       rst3, in_valid3, in_ready3, s2_3, s1_3, s0_3, out_valid3, drop3;
    logic [0:0] in_data3, d3;
    logic [7:0] ch_ready3, ch_mask3, stall_cnt3;
    logic [2:0] sel3;
    assign sel3 = {s2_3, s1_3, s0_3};

    int checks = 0;
    int errors = 0;

    demux_rr_dispatcher #(.DW(1), .HOLD(1), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ch_ready(ch_ready), .ch_mask(ch_mask), .d(d),
        .s2(s2), .s1(s1), .s0(s0), .out_valid(out_valid), .drop(drop),
        .stall_cnt(stall_cnt)
    );

    demux_rr_dispatcher #(.DW(1), .HOLD(3), .TIMEOUT(16)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .ch_ready(ch_ready3), .ch_mask(ch_mask3), .d(d3),
        .s2(s2_3), .s1(s1_3), .s0(s0_3), .out_valid(out_valid3), .drop(drop3),
        .stall_cnt(stall_cnt3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Waits (bounded) for in_ready, then performs one handshake; returns
    // with the HOLD=1 instance in ARB.
    task automatic send_word(input logic data);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL send_word_ready: got %0b expected 1", in_ready); end
        in_data = data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0;
        ch_ready = 8'hFF; ch_mask = 8'hFF;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready_during: got %0b expected 0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_after: got %0b expected 1", in_ready); end
        checks++;
        if ({out_valid, drop, d, sel} !== 6'b0) begin errors++; $display("[TB] FAIL reset_outputs: got ov=%0b drop=%0b d=%0b sel=%0d expected all 0", out_valid, drop, d, sel); end
        checks++;
        if (stall_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cnt); end
        send_word(1'b1);
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("[TB] FAIL first_arb: got ov=%0b rdy=%0b expected 0 0", out_valid, in_ready); end
        tick();
        checks++;
        if ({out_valid, d, sel} !== {1'b1, 1'b1, 3'd0}) begin errors++; $display("[TB] FAIL first_grant: got ov=%0b d=%0b sel=%0d expected 1 1 0", out_valid, d, sel); end
        tick();
        checks++;
        if ({out_valid, d, in_ready} !== 3'b001) begin errors++; $display("[TB] FAIL first_release: got ov=%0b d=%0b rdy=%0b expected 0 0 1", out_valid, d, in_ready); end
    endtask

    task automatic test_back_to_back;
        logic exp_d;
        do_reset();
        ch_ready = 8'hFF; ch_mask = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_d = ~i[0];
            in_data = exp_d;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %0b expected 1", i, in_ready); end
            tick();
            checks++;
            if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_arb[%0d]: got rdy=%0b ov=%0b expected 0 0", i, in_ready, out_valid); end
            tick();
            checks++;
            if ({out_valid, sel, d} !== {1'b1, 3'(i % 8), exp_d}) begin errors++; $display("[TB] FAIL b2b_grant[%0d]: got ov=%0b sel=%0d d=%0b expected 1 %0d %0b", i, out_valid, sel, d, i % 8, exp_d); end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_release[%0d]: got %0b expected 0", i, out_valid); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_priority;
        logic [2:0] exp_g [4] = '{3'd5, 3'd7, 3'd2, 3'd5};
        do_reset();
        ch_mask = 8'hFF; ch_ready = 8'h04;
        send_word(1'b1);
        tick();
        checks++;
        if (sel !== 3'd2) begin errors++; $display("[TB] FAIL prio_setup: got sel=%0d expected 2", sel); end
        tick();
        ch_mask = 8'b1010_0100; ch_ready = 8'hFF;
        for (int j = 0; j < 4; j++) begin
            send_word(1'b1);
            tick();
            checks++;
            if ({out_valid, sel} !== {1'b1, exp_g[j]}) begin errors++; $display("[TB] FAIL prio_grant[%0d]: got ov=%0b sel=%0d expected 1 %0d", j, out_valid, sel, exp_g[j]); end
            tick();
        end
    endtask

    task automatic test_single;
        ch_mask = 8'hFF; ch_ready = 8'h10;
        for (int j = 0; j < 2; j++) begin
            send_word(1'b1);
            tick();
            checks++;
            if ({out_valid, sel} !== {1'b1, 3'd4}) begin errors++; $display("[TB] FAIL single_grant[%0d]: got ov=%0b sel=%0d expected 1 4", j, out_valid, sel); end
            tick();
        end
    endtask

    task automatic test_timeout;
        do_reset();
        ch_mask = 8'h00; ch_ready = 8'hFF;
        send_word(1'b1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if ({drop, out_valid, d} !== 3'b000) begin errors++; $display("[TB] FAIL to_wait[%0d]: got drop=%0b ov=%0b d=%0b expected 0 0 0", k, drop, out_valid, d); end
            if (k == 8) begin
                checks++;
                if (stall_cnt !== 8'd8) begin errors++; $display("[TB] FAIL to_stall_mid: got %0d expected 8", stall_cnt); end
            end
        end
        tick();
        checks++;
        if ({drop, in_ready, d} !== 3'b110) begin errors++; $display("[TB] FAIL to_drop: got drop=%0b rdy=%0b d=%0b expected 1 1 0", drop, in_ready, d); end
        checks++;
        if (stall_cnt !== 8'd16) begin errors++; $display("[TB] FAIL to_stall: got %0d expected 16", stall_cnt); end
        tick();
        checks++;
        if ({drop, stall_cnt} !== {1'b0, 8'd16}) begin errors++; $display("[TB] FAIL to_after: got drop=%0b stall=%0d expected 0 16", drop, stall_cnt); end
    endtask

    task automatic test_grant_beats_timeout;
        do_reset();
        ch_mask = 8'h00; ch_ready = 8'hFF;
        send_word(1'b1);
        for (int k = 1; k <= 15; k++) tick();
        ch_mask = 8'h08;
        tick();
        checks++;
        if ({drop, out_valid, sel} !== {1'b0, 1'b1, 3'd3}) begin errors++; $display("[TB] FAIL gbt_grant: got drop=%0b ov=%0b sel=%0d expected 0 1 3", drop, out_valid, sel); end
        checks++;
        if (stall_cnt !== 8'd15) begin errors++; $display("[TB] FAIL gbt_stall: got %0d expected 15", stall_cnt); end
        tick();
        ch_mask = 8'hFF;
    endtask

    task automatic test_hold3;
        rst3 = 1'b1; in_valid3 = 1'b0; in_data3 = 1'b0;
        ch_mask3 = 8'hFF; ch_ready3 = 8'h40;
        tick();
        tick();
        rst3 = 1'b0;
        #1;
        checks++;
        if (in_ready3 !== 1'b1) begin errors++; $display("[TB] FAIL h3_ready: got %0b expected 1", in_ready3); end
        in_data3 = 1'b1; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        checks++;
        if ({out_valid3, sel3, d3} !== {1'b1, 3'd6, 1'b1}) begin errors++; $display("[TB] FAIL h3_grant: got ov=%0b sel=%0d d=%0b expected 1 6 1", out_valid3, sel3, d3); end
        ch_ready3 = 8'h00;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({out_valid3, sel3, d3} !== {1'b1, 3'd6, 1'b1}) begin errors++; $display("[TB] FAIL h3_hold[%0d]: got ov=%0b sel=%0d d=%0b expected 1 6 1", k, out_valid3, sel3, d3); end
        end
        tick();
        checks++;
        if ({out_valid3, d3, sel3, in_ready3} !== {1'b0, 1'b0, 3'd6, 1'b1}) begin errors++; $display("[TB] FAIL h3_release: got ov=%0b d=%0b sel=%0d rdy=%0b expected 0 0 6 1", out_valid3, d3, sel3, in_ready3); end
    endtask

    task automatic test_reset_mid_drive;
        ch_ready3 = 8'hFF;
        in_data3 = 1'b1; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        checks++;
        if ({out_valid3, sel3} !== {1'b1, 3'd7}) begin errors++; $display("[TB] FAIL rmd_grant: got ov=%0b sel=%0d expected 1 7", out_valid3, sel3); end
        tick();
        rst3 = 1'b1;
        tick();
        checks++;
        if ({out_valid3, d3, sel3, drop3, in_ready3} !== 7'b0) begin errors++; $display("[TB] FAIL rmd_reset: got ov=%0b d=%0b sel=%0d drop=%0b rdy=%0b expected all 0", out_valid3, d3, sel3, drop3, in_ready3); end
        rst3 = 1'b0;
        #1;
        checks++;
        if (in_ready3 !== 1'b1) begin errors++; $display("[TB] FAIL rmd_ready: got %0b expected 1", in_ready3); end
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        checks++;
        if ({out_valid3, sel3} !== {1'b1, 3'd0}) begin errors++; $display("[TB] FAIL rmd_next_grant: got ov=%0b sel=%0d expected 1 0", out_valid3, sel3); end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; ch_ready = 8'hFF; ch_mask = 8'hFF;
        rst3 = 1'b1; in_valid3 = 1'b0; in_data3 = 1'b0; ch_ready3 = 8'hFF; ch_mask3 = 8'hFF;
        test_reset();
        test_back_to_back();
        test_priority();
        test_single();
        test_timeout();
        test_grant_beats_timeout();
        test_hold3();
        test_reset_mid_drive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
